core_lsu: RTL and testbench

Load/store unit for the core's memory stage, directly downstream of `core_alu`. It takes the ALU's effective address (RS1 + IMM), the store data (RS2) and the one-hot load/store instruction flags. It runs a single outstanding request/acknowledge transaction on the data-memory bus and returns aligned, sign- or zero-extended load data, or a store completion, to write-back. It also reports misalignment, bus-error and timeout exceptions.

---
 rtl/core_lsu_pkg.sv | 50 +++++
 rtl/core_lsu_align.sv | 58 +++++
 rtl/core_lsu.sv | 160 ++++++++++++++++
 tb/tb_core_lsu.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/core_lsu_pkg.sv
// core_lsu_pkg: shared types and constants for the load/store unit.
//   state_e     : FSM states (IDLE, REQ, RESP)
//   CAUSE_*     : exception cause codes reported on o_cause
//   op_t        : internal op encoding (size, unsigned, store)
//   decode_op   : one-hot flag vector {lb,lh,lw,lbu,lhu,sb,sh,sw} -> op_t
package core_lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b00;
    localparam logic [1:0] CAUSE_MIS_LD  = 2'b01;
    localparam logic [1:0] CAUSE_MIS_ST  = 2'b10;
    localparam logic [1:0] CAUSE_BUS     = 2'b11;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam int DEFAULT_TIMEOUT = 255;

    typedef struct packed {
        logic [1:0] size;
        logic       uns;
        logic       store;
    } op_t;

    // Illegal flag combinations decode to all-zero; the caller detects them
    // separately with $onehot.
    function automatic op_t decode_op(input logic [7:0] f);
        op_t o;
        o = '0;
        case (f)
            8'b1000_0000: begin o.size = SZ_B; end
            8'b0100_0000: begin o.size = SZ_H; end
            8'b0010_0000: begin o.size = SZ_W; end
            8'b0001_0000: begin o.size = SZ_B; o.uns = 1'b1; end
            8'b0000_1000: begin o.size = SZ_H; o.uns = 1'b1; end
            8'b0000_0100: begin o.size = SZ_B; o.store = 1'b1; end
            8'b0000_0010: begin o.size = SZ_H; o.store = 1'b1; end
            8'b0000_0001: begin o.size = SZ_W; o.store = 1'b1; end
            default:      o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/core_lsu_align.sv
// core_lsu_align: combinational lane logic for the LSU.
//   op_i, a_i     : operation and byte offset addr[1:0]
//   wdata_i       : raw store data (RS2)
//   rdata_i       : raw bus read data
//   be_o          : byte enables
//   wdata_o       : lane-replicated store data
//   ldata_o       : shifted and sign/zero-extended load data
//   misalign_o    : access is misaligned and must trap
// Macro CORE_LSU_MISALIGN_TRAP_EN: when defined, misaligned halfword/word
// accesses raise misalign_o; when undefined the offset is truncated instead.
module core_lsu_align
    import core_lsu_pkg::*;
(
    input  op_t         op_i,
    input  logic [1:0]  a_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ldata_o,
    output logic        misalign_o
);

    logic [1:0]  eff_a;
    logic [31:0] sh;

    always_comb begin
        eff_a      = a_i;
        misalign_o = 1'b0;
`ifdef CORE_LSU_MISALIGN_TRAP_EN
        misalign_o = ((op_i.size == SZ_H) && a_i[0]) ||
                     ((op_i.size == SZ_W) && (a_i != 2'b00));
`else
        if (op_i.size == SZ_H) eff_a[0] = 1'b0;
        if (op_i.size == SZ_W) eff_a    = 2'b00;
`endif
        sh = rdata_i >> {eff_a, 3'b000};

        case (op_i.size)
            SZ_B: begin
                be_o    = 4'b0001 << eff_a;
                wdata_o = {4{wdata_i[7:0]}};
                ldata_o = op_i.uns ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            end
            SZ_H: begin
                be_o    = 4'b0011 << eff_a;
                wdata_o = {2{wdata_i[15:0]}};
                ldata_o = op_i.uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            end
            default: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                ldata_o = sh;
            end
        endcase
    end

endmodule

// File: rtl/core_lsu.sv
// core_lsu: single-outstanding load/store unit for the memory stage.
//   clk, rst          : clock, async active-high reset
//   i_valid/i_ready   : request handshake from execute
//   i_lb..i_sw        : one-hot op flags; addr, wdata, rd_tag operands
//   mem_*             : req/ack data-memory bus
//   o_valid..o_cause  : one-cycle result / exception to write-back
// Misalignment trapping is selected by CORE_LSU_MISALIGN_TRAP_EN (see
// core_lsu_align).
module core_lsu
    import core_lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    output logic        i_ready,
    input  logic        i_lb,
    input  logic        i_lh,
    input  logic        i_lw,
    input  logic        i_lbu,
    input  logic        i_lhu,
    input  logic        i_sb,
    input  logic        i_sh,
    input  logic        i_sw,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [4:0]  rd_tag,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err,
    output logic        o_valid,
    output logic        o_we,
    output logic [4:0]  o_rd,
    output logic [31:0] o_rdata,
    output logic        o_exc,
    output logic [1:0]  o_cause
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);

    state_e      state_q, state_d;
    op_t         op_q, op_in, op_sel;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [4:0]  tag_q;
    logic        exc_q;
    logic [1:0]  cause_q;
    logic [CW-1:0] cnt_q, cnt_nx;

    logic [7:0]  flags;
    logic        illegal, misalign, trap, accept, timeout, idle;
    logic [1:0]  a_sel;
    logic [3:0]  be;
    logic [31:0] wrep, ldata;

    assign flags   = {i_lb, i_lh, i_lw, i_lbu, i_lhu, i_sb, i_sh, i_sw};
    assign op_in   = decode_op(flags);
    assign illegal = !$onehot(flags);
    assign idle    = (state_q == ST_IDLE);
    assign accept  = i_valid && idle;

    // In IDLE the aligner looks at the incoming request so misalignment is
    // known at accept; afterwards it works from the latched op.
    assign op_sel  = idle ? op_in       : op_q;
    assign a_sel   = idle ? addr[1:0]   : addr_q[1:0];
    assign trap    = illegal || misalign;

    assign cnt_nx  = cnt_q + 1'b1;
    assign timeout = (cnt_nx == TO_LIMIT);

    core_lsu_align u_align (
        .op_i       (op_sel),
        .a_i        (a_sel),
        .wdata_i    (wdata_q),
        .rdata_i    (rdata_q),
        .be_o       (be),
        .wdata_o    (wrep),
        .ldata_o    (ldata),
        .misalign_o (misalign)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (i_valid) state_d = trap ? ST_RESP : ST_REQ;
            ST_REQ:  if (mem_ack || timeout) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: everything is gated by state so idle/reset values are zero.
    always_comb begin
        i_ready   = idle;
        mem_req   = (state_q == ST_REQ);
        mem_we    = mem_req && op_q.store;
        mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : 32'b0;
        mem_be    = mem_req ? be : 4'b0;
        mem_wdata = mem_we ? wrep : 32'b0;
        o_valid   = (state_q == ST_RESP);
        o_we      = o_valid && !exc_q && !op_q.store;
        o_rd      = o_valid ? tag_q : 5'b0;
        o_rdata   = o_we ? ldata : 32'b0;
        o_exc     = o_valid && exc_q;
        o_cause   = o_exc ? cause_q : 2'b00;
    end

    // Transaction registers and timeout counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            tag_q   <= '0;
            exc_q   <= 1'b0;
            cause_q <= CAUSE_ILLEGAL;
            cnt_q   <= '0;
        end else begin
            if (accept) begin
                op_q    <= op_in;
                addr_q  <= addr;
                wdata_q <= wdata;
                rdata_q <= '0;
                tag_q   <= rd_tag;
                exc_q   <= trap;
                cause_q <= illegal ? CAUSE_ILLEGAL :
                           (op_in.store ? CAUSE_MIS_ST : CAUSE_MIS_LD);
            end
            if (state_q == ST_REQ) begin
                if (mem_ack) begin
                    rdata_q <= mem_rdata;
                    exc_q   <= mem_err;
                    cause_q <= CAUSE_BUS;
                    cnt_q   <= '0;
                end else if (timeout) begin
                    exc_q   <= 1'b1;
                    cause_q <= CAUSE_BUS;
                    cnt_q   <= '0;
                end else begin
                    cnt_q   <= cnt_nx;
                end
            end
        end
    end

endmodule

// File: tb/tb_core_lsu.sv
// tb_core_lsu: scoreboard bench for core_lsu (TIMEOUT_CYCLES = 8).
// Expected write-back results are queued when a request is driven and
// compared when o_valid pulses; bus-side values are checked inline.
module tb_core_lsu;

    localparam int TO = 8;

    localparam logic [7:0] F_LB  = 8'b1000_0000;
    localparam logic [7:0] F_LH  = 8'b0100_0000;
    localparam logic [7:0] F_LW  = 8'b0010_0000;
    localparam logic [7:0] F_LBU = 8'b0001_0000;
    localparam logic [7:0] F_LHU = 8'b0000_1000;
    localparam logic [7:0] F_SB  = 8'b0000_0100;
    localparam logic [7:0] F_SH  = 8'b0000_0010;
    localparam logic [7:0] F_SW  = 8'b0000_0001;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic        exc;
        logic [1:0]  cause;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid, i_ready;
    logic [7:0]  fl_r;
    logic [31:0] addr, wdata;
    logic [4:0]  rd_tag;
    logic        mem_req, mem_we, mem_ack, mem_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        o_valid, o_we, o_exc;
    logic [4:0]  o_rd;
    logic [31:0] o_rdata;
    logic [1:0]  o_cause;

    int   n_chk  = 0;
    int   n_fail = 0;
    res_t exp_q[$];
    res_t mon_e;

    logic [31:0] lane_exp [4] = '{32'h0000007F, 32'hFFFFFFC2, 32'h00000040, 32'hFFFFFF81};
    logic [3:0]  lane_be  [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    always #5 clk = ~clk;

    core_lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_ready(i_ready),
        .i_lb(fl_r[7]), .i_lh(fl_r[6]), .i_lw(fl_r[5]), .i_lbu(fl_r[4]),
        .i_lhu(fl_r[3]), .i_sb(fl_r[2]), .i_sh(fl_r[1]), .i_sw(fl_r[0]),
        .addr(addr), .wdata(wdata), .rd_tag(rd_tag),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err),
        .o_valid(o_valid), .o_we(o_we), .o_rd(o_rd), .o_rdata(o_rdata),
        .o_exc(o_exc), .o_cause(o_cause)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: every o_valid pulse must match the oldest queued result.
    always @(negedge clk) begin
        if (!rst && o_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_o_valid", {31'b0, o_valid}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("o_we",    {31'b0, o_we},    {31'b0, mon_e.we});
                check("o_rd",    {27'b0, o_rd},    {27'b0, mon_e.rd});
                check("o_rdata", o_rdata,          mon_e.rdata);
                check("o_exc",   {31'b0, o_exc},   {31'b0, mon_e.exc});
                check("o_cause", {30'b0, o_cause}, {30'b0, mon_e.cause});
            end
        end
    end

    // dly < 0 means never ack (timeout path).
    task automatic run_op(input string nm, input logic [7:0] fl, input logic [31:0] ad,
                          input logic [31:0] wd, input logic [4:0] tg, input bit bus,
                          input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] rd,
                          input bit err, input int dly, input logic [31:0] eres,
                          input bit eexc, input logic [1:0] ecause);
        res_t r;
        int   n;
        @(posedge clk); #1;
        check({nm, "_ready"}, {31'b0, i_ready}, 32'd1);
        i_valid = 1'b1; fl_r = fl; addr = ad; wdata = wd; rd_tag = tg;
        r.we    = !eexc && (fl[7:3] != 5'b0);
        r.rd    = tg;
        r.rdata = eres;
        r.exc   = eexc;
        r.cause = eexc ? ecause : 2'b00;
        exp_q.push_back(r);
        @(posedge clk); #1;
        i_valid = 1'b0; fl_r = '0;
        if (!bus) begin
            check({nm, "_no_req"},    {31'b0, mem_req}, 32'd0);
            check({nm, "_valid_c1"},  {31'b0, o_valid}, 32'd1);
        end else begin
            check({nm, "_req"},  {31'b0, mem_req}, 32'd1);
            check({nm, "_addr"}, mem_addr, {ad[31:2], 2'b00});
            check({nm, "_be"},   {28'b0, mem_be}, {28'b0, ebe});
            check({nm, "_we"},   {31'b0, mem_we}, {31'b0, (fl[2:0] != 3'b0)});
            if (fl[2:0] != 3'b0) check({nm, "_wdata"}, mem_wdata, ewd);
            if (dly < 0) begin
                n = 0;
                while (mem_req && n < 50) begin
                    n++;
                    @(posedge clk); #1;
                end
                check({nm, "_req_cycles"}, n, TO);
                check({nm, "_valid_after_to"}, {31'b0, o_valid}, 32'd1);
            end else begin
                repeat (dly) begin
                    @(posedge clk); #1;
                    check({nm, "_req_held"}, {31'b0, mem_req}, 32'd1);
                end
                mem_ack = 1'b1; mem_rdata = rd; mem_err = err;
                @(posedge clk); #1;
                mem_ack = 1'b0; mem_rdata = '0; mem_err = 1'b0;
                check({nm, "_valid_ack1"}, {31'b0, o_valid}, 32'd1);
                check({nm, "_req_drop"},   {31'b0, mem_req}, 32'd0);
            end
        end
        @(posedge clk); #1;
        check({nm, "_valid_1cyc"}, {31'b0, o_valid}, 32'd0);
        check({nm, "_idle"},       {31'b0, i_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; i_valid = 1'b0; fl_r = '0; addr = '0; wdata = '0; rd_tag = '0;
        mem_ack = 1'b0; mem_rdata = '0; mem_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready",  {31'b0, i_ready}, 32'd1);
        check("rst_req",    {31'b0, mem_req}, 32'd0);
        check("rst_valid",  {31'b0, o_valid}, 32'd0);
        check("rst_be",     {28'b0, mem_be},  32'd0);
        rst = 1'b0;

        run_op("sw",  F_SW,  32'h100, 32'hDEADBEEF, 5'd1, 1, 4'b1111, 32'hDEADBEEF, 32'h0, 0, 2, 32'h0, 0, 2'b00);
        run_op("lb",  F_LB,  32'h103, 32'h0, 5'd5, 1, 4'b1000, 32'h0, 32'h80FF1234, 0, 0, 32'hFFFFFF80, 0, 2'b00);
        run_op("lbu", F_LBU, 32'h103, 32'h0, 5'd6, 1, 4'b1000, 32'h0, 32'h80FF1234, 0, 1, 32'h00000080, 0, 2'b00);
        run_op("lh",  F_LH,  32'h102, 32'h0, 5'd7, 1, 4'b1100, 32'h0, 32'h80010000, 0, 0, 32'hFFFF8001, 0, 2'b00);
        run_op("lhu", F_LHU, 32'h102, 32'h0, 5'd8, 1, 4'b1100, 32'h0, 32'h80010000, 0, 0, 32'h00008001, 0, 2'b00);
        run_op("sb",  F_SB,  32'h101, 32'h000000AB, 5'd2, 1, 4'b0010, 32'hABABABAB, 32'h0, 0, 0, 32'h0, 0, 2'b00);
`ifdef CORE_LSU_MISALIGN_TRAP_EN
        run_op("sh_mis", F_SH, 32'h101, 32'h1234CDEF, 5'd3, 0, 4'b0, 32'h0, 32'h0, 0, 0, 32'h0, 1, 2'b10);
        run_op("lw_mis", F_LW, 32'h102, 32'h0, 5'd4, 0, 4'b0, 32'h0, 32'h0, 0, 0, 32'h0, 1, 2'b01);
`else
        run_op("sh_mis", F_SH, 32'h101, 32'h1234CDEF, 5'd3, 1, 4'b0011, 32'hCDEFCDEF, 32'h0, 0, 0, 32'h0, 0, 2'b00);
        run_op("lw_mis", F_LW, 32'h102, 32'h0, 5'd4, 1, 4'b1111, 32'h0, 32'hCAFEF00D, 0, 0, 32'hCAFEF00D, 0, 2'b00);
`endif
        run_op("flags0",  8'h00,         32'h100, 32'h0, 5'd9,  0, 4'b0, 32'h0, 32'h0, 0, 0, 32'h0, 1, 2'b00);
        run_op("lw_sw",   F_LW | F_SW,   32'h100, 32'h0, 5'd10, 0, 4'b0, 32'h0, 32'h0, 0, 0, 32'h0, 1, 2'b00);
        run_op("lw_to",   F_LW,          32'h200, 32'h0, 5'd11, 1, 4'b1111, 32'h0, 32'h0, 0, -1, 32'h0, 1, 2'b11);
        run_op("lw_err",  F_LW,          32'h204, 32'h0, 5'd12, 1, 4'b1111, 32'h0, 32'h12345678, 1, 1, 32'h0, 1, 2'b11);
        for (int i = 0; i < 4; i++)
            run_op("lb_lane", F_LB, 32'h300 + i, 32'h0, 5'd13, 1, lane_be[i], 32'h0, 32'h8140C27F, 0, 0, lane_exp[i], 0, 2'b00);

        // Reset in the middle of a bus request.
        @(posedge clk); #1;
        i_valid = 1'b1; fl_r = F_LW; addr = 32'h400; rd_tag = 5'd20;
        @(posedge clk); #1;
        i_valid = 1'b0; fl_r = '0;
        check("mid_req", {31'b0, mem_req}, 32'd1);
        #2 rst = 1'b1;
        #1 check("rst_async_req", {31'b0, mem_req}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("post_rst_ready", {31'b0, i_ready}, 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
        @(posedge clk); #1;
        mem_ack = 1'b0; mem_rdata = '0;
        check("late_ack_valid", {31'b0, o_valid}, 32'd0);
        @(posedge clk); #1;
        check("late_ack_valid2", {31'b0, o_valid}, 32'd0);
        check("late_ack_req",    {31'b0, mem_req}, 32'd0);
        run_op("lw_after_rst", F_LW, 32'h404, 32'h0, 5'd21, 1, 4'b1111, 32'h0, 32'h87654321, 0, 0, 32'h87654321, 0, 2'b00);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
